// File: rtl/laser_frame_tracker_pkg.sv
// Shared types and helpers for the laser frame tracker.
//   COORD_W       : width of one laser coordinate
//   ERR_W         : width of one signed aim-error axis
//   frame_state_t : frame FSM states
//   aim_err()     : target - average as 17-bit two's complement
package laser_frame_tracker_pkg;

  localparam int COORD_W = 16;
  localparam int ERR_W   = 17;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_ACCUM   = 2'd3
  } frame_state_t;

  // Zero-extend both operands so any unsigned coordinate pair fits.
  function automatic logic [ERR_W-1:0] aim_err(input logic [COORD_W-1:0] tgt,
                                              input logic [COORD_W-1:0] avg);
    return {1'b0, tgt} - {1'b0, avg};
  endfunction

endpackage

// File: rtl/laser_avg_ring.sv
// Running average of the last 2^AVG_LOG2 found laser positions.
//   clk, reset    : clock, synchronous active-high reset
//   push          : write din_x/din_y as the newest sample
//   flush         : empty the ring (avg_x/avg_y keep their last value)
//   din_x, din_y  : sample to push
//   avg_x, avg_y  : mean of the ring when full, else the newest sample
//   full          : ring holds 2^AVG_LOG2 samples
module laser_avg_ring
  import laser_frame_tracker_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               flush,
  input  logic [COORD_W-1:0] din_x,
  input  logic [COORD_W-1:0] din_y,
  output logic [COORD_W-1:0] avg_x,
  output logic [COORD_W-1:0] avg_y,
  output logic               full
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = COORD_W + AVG_LOG2;

  logic [COORD_W-1:0]  ring_x [DEPTH];
  logic [COORD_W-1:0]  ring_y [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [AVG_LOG2:0]   fill;
  logic [SUM_W-1:0]    sum_x, sum_y;
  logic [SUM_W-1:0]    sum_x_nx, sum_y_nx;
  logic [COORD_W-1:0]  evict_x, evict_y;
  logic                full_nx;

  assign full = (fill == (AVG_LOG2+1)'(DEPTH));

  // Slots are only meaningful once the ring has wrapped; before that
  // (including right after a flush) nothing is evicted.
  assign evict_x  = full ? ring_x[wr_ptr] : '0;
  assign evict_y  = full ? ring_y[wr_ptr] : '0;
  assign sum_x_nx = sum_x + SUM_W'(din_x) - SUM_W'(evict_x);
  assign sum_y_nx = sum_y + SUM_W'(din_y) - SUM_W'(evict_y);
  assign full_nx  = full || (fill == (AVG_LOG2+1)'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (push) begin
      ring_x[wr_ptr] <= din_x;
      ring_y[wr_ptr] <= din_y;
    end
  end

  // avg is registered and only moves on push, so a flush leaves the
  // last reported position in place while the ring refills.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      fill   <= '0;
      sum_x  <= '0;
      sum_y  <= '0;
      avg_x  <= '0;
      avg_y  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      fill   <= '0;
      sum_x  <= '0;
      sum_y  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
      fill   <= full ? fill : fill + 1'b1;
      sum_x  <= sum_x_nx;
      sum_y  <= sum_y_nx;
      avg_x  <= full_nx ? sum_x_nx[SUM_W-1:AVG_LOG2] : din_x;
      avg_y  <= full_nx ? sum_y_nx[SUM_W-1:AVG_LOG2] : din_y;
    end
  end

endmodule

// File: rtl/laser_frame_tracker.sv
// Frame tracker sitting behind the laser detector.
//   clk, reset            : clock, synchronous active-high reset
//   en, pixel_col/row     : pixel strobe and coordinates
//   laser_xy              : detector result {x, y}, 0 = not found
//   target_xy             : aim point {x, y}
//   det_clear             : one-cycle detector restart after each frame
//   err_valid/err_ready   : aim error handshake, err_x/err_y = target - avg
//   avg_xy                : averaged position {x, y}
//   lost                  : no lock
//   overrun               : sticky, a found-frame result was dropped
//   frame_count           : completed frames
module laser_frame_tracker
  import laser_frame_tracker_pkg::*;
#(
  parameter int FRAME_W     = 640,
  parameter int FRAME_H     = 480,
  parameter int AVG_LOG2    = 2,
  parameter int LOST_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] pixel_col,
  input  logic [15:0] pixel_row,
  input  logic [31:0] laser_xy,
  input  logic [31:0] target_xy,
  output logic        det_clear,
  output logic        err_valid,
  input  logic        err_ready,
  output logic [16:0] err_x,
  output logic [16:0] err_y,
  output logic [31:0] avg_xy,
  output logic        lost,
  output logic        overrun,
  output logic [15:0] frame_count
);

  frame_state_t       state;
  logic [31:0]        cap_xy;
  logic [7:0]         miss;
  logic               sof, eof, found, push, flush, load;
  logic [COORD_W-1:0] avg_x, avg_y;
  logic               ring_full;

  assign sof = en && (pixel_col == 16'd0) && (pixel_row == 16'd0);
  assign eof = en && (pixel_col == 16'(FRAME_W - 1)) && (pixel_row == 16'(FRAME_H - 1));

  assign found = (cap_xy != 32'd0);

  // The ring is pushed from the same value being latched into cap_xy,
  // so its average is already settled when ACCUM computes the error.
  assign push  = (state == ST_CAPTURE) && (laser_xy != 32'd0);
  // Flush exactly on the miss that reaches the loss threshold.
  assign flush = (state == ST_ACCUM) && !found && (miss == 8'(LOST_FRAMES - 1));
  assign load  = (state == ST_ACCUM) && found && (!err_valid || err_ready);

  laser_avg_ring #(.AVG_LOG2(AVG_LOG2)) u_ring (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .flush (flush),
    .din_x (laser_xy[31:16]),
    .din_y (laser_xy[15:0]),
    .avg_x (avg_x),
    .avg_y (avg_y),
    .full  (ring_full)
  );

  assign avg_xy = {avg_x, avg_y};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cap_xy      <= '0;
      miss        <= 8'(LOST_FRAMES);
      lost        <= 1'b1;
      det_clear   <= 1'b0;
      err_valid   <= 1'b0;
      err_x       <= '0;
      err_y       <= '0;
      overrun     <= 1'b0;
      frame_count <= '0;
    end else begin
      det_clear <= 1'b0;
      case (state)
        ST_IDLE: if (sof) state <= ST_RUN;
        ST_RUN: begin
          // Registered so det_clear and the new count are seen at EOF+1.
          if (eof) begin
            state       <= ST_CAPTURE;
            det_clear   <= 1'b1;
            frame_count <= frame_count + 16'd1;
          end
        end
        ST_CAPTURE: begin
          cap_xy <= laser_xy;
          state  <= ST_ACCUM;
        end
        default: begin
          state <= ST_RUN;
          if (found) begin
            miss <= '0;
            lost <= 1'b0;
          end else if (miss < 8'(LOST_FRAMES)) begin
            miss <= miss + 8'd1;
            if (miss == 8'(LOST_FRAMES - 1)) lost <= 1'b1;
          end
        end
      endcase

      if (load) begin
        err_valid <= 1'b1;
        err_x     <= aim_err(target_xy[31:16], avg_x);
        err_y     <= aim_err(target_xy[15:0], avg_y);
      end else if (err_valid && err_ready) begin
        err_valid <= 1'b0;
      end

      if ((state == ST_ACCUM) && found && err_valid && !err_ready)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_laser_frame_tracker.sv
module tb_laser_frame_tracker;

  localparam int FW = 8, FH = 4, AL = 2, LF = 3;
  localparam int NPIX = FW * FH;
  localparam int DEPTH = 1 << AL;

  logic        clk = 1'b0;
  logic        reset, en, err_ready;
  logic [15:0] pixel_col, pixel_row;
  logic [31:0] laser_xy, target_xy;
  logic        det_clear, err_valid, lost, overrun;
  logic [16:0] err_x, err_y;
  logic [31:0] avg_xy;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  laser_frame_tracker #(.FRAME_W(FW), .FRAME_H(FH), .AVG_LOG2(AL), .LOST_FRAMES(LF)) dut (
    .clk(clk), .reset(reset), .en(en), .pixel_col(pixel_col), .pixel_row(pixel_row),
    .laser_xy(laser_xy), .target_xy(target_xy), .det_clear(det_clear),
    .err_valid(err_valid), .err_ready(err_ready), .err_x(err_x), .err_y(err_y),
    .avg_xy(avg_xy), .lost(lost), .overrun(overrun), .frame_count(frame_count)
  );

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: list of found samples since the last flush.
  int unsigned hq_x[$], hq_y[$];
  logic [15:0] m_ax, m_ay, m_fc;
  logic [16:0] m_ex, m_ey;
  int          m_miss;
  bit          m_lost, m_pend, m_ovr;

  task automatic model_reset();
    hq_x.delete(); hq_y.delete();
    m_ax = 0; m_ay = 0; m_fc = 0; m_ex = 0; m_ey = 0;
    m_miss = LF; m_lost = 1; m_pend = 0; m_ovr = 0;
  endtask

  task automatic model_accum(input logic [31:0] xy, input logic [31:0] tgt, input bit rdy);
    int unsigned sx, sy;
    if (xy != 0) begin
      if (hq_x.size() == DEPTH) begin
        void'(hq_x.pop_front()); void'(hq_y.pop_front());
      end
      hq_x.push_back(xy[31:16]); hq_y.push_back(xy[15:0]);
      if (hq_x.size() == DEPTH) begin
        sx = 0; sy = 0;
        foreach (hq_x[i]) begin sx += hq_x[i]; sy += hq_y[i]; end
        m_ax = 16'(sx / DEPTH); m_ay = 16'(sy / DEPTH);
      end else begin
        m_ax = xy[31:16]; m_ay = xy[15:0];
      end
      m_miss = 0; m_lost = 0;
      if (!m_pend || rdy) begin
        m_pend = 1;
        m_ex = {1'b0, tgt[31:16]} - {1'b0, m_ax};
        m_ey = {1'b0, tgt[15:0]} - {1'b0, m_ay};
      end else m_ovr = 1;
    end else begin
      if (m_pend && rdy) m_pend = 0;
      if (m_miss < LF) begin
        m_miss++;
        if (m_miss == LF) begin m_lost = 1; hq_x.delete(); hq_y.delete(); end
      end
    end
  endtask

  // Drive one pixel, let one edge pass, update model and check handshake.
  task automatic step(input int pix, input bit accum);
    pixel_col = 16'(pix % FW);
    pixel_row = 16'(pix / FW);
    @(posedge clk); #1;
    if (reset) model_reset();
    else if (accum) model_accum(laser_xy, target_xy, err_ready);
    else if (m_pend && err_ready) m_pend = 0;
    chk("err_valid", {31'd0, err_valid}, {31'd0, m_pend});
    if (m_pend) begin
      chk("err_x", {15'd0, err_x}, {15'd0, m_ex});
      chk("err_y", {15'd0, err_y}, {15'd0, m_ey});
    end
  endtask

  // Pixels 2..NPIX-1 of a frame then 0,1 of the next (capture + accum).
  task automatic run_frame(input logic [31:0] xy, input logic [31:0] tgt, input bit rdy);
    laser_xy = xy; target_xy = tgt; err_ready = rdy;
    for (int i = 2; i < NPIX + 2; i++) begin
      int pix;
      pix = i % NPIX;
      step(pix, pix == 1);
      if (pix == NPIX - 1) begin
        m_fc++;
        chk("det_clear_eof1", {31'd0, det_clear}, 32'd1);
        chk("frame_count", {16'd0, frame_count}, {16'd0, m_fc});
      end
      if (pix == 0) chk("det_clear_eof2", {31'd0, det_clear}, 32'd0);
      if (pix == 1) begin
        chk("avg_xy", avg_xy, {m_ax, m_ay});
        chk("lost", {31'd0, lost}, {31'd0, m_lost});
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
      end
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_det_clear", {31'd0, det_clear}, 32'd0);
    chk("rst_lost", {31'd0, lost}, 32'd1);
    chk("rst_avg", avg_xy, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
    chk("rst_err", {15'd0, err_x}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] xy;
    bit          rdy;
    bit          e_v;
    logic [16:0] e_ex, e_ey;
    logic [15:0] e_ax, e_ay;
    bit          e_lost, e_ovr;
  } vec_t;

  function automatic vec_t mk(input int x, input int y, input bit rdy, input bit v,
                              input int ex, input int ey, input int ax, input int ay,
                              input bit l, input bit o);
    vec_t r;
    r.xy = {16'(x), 16'(y)}; r.rdy = rdy; r.e_v = v;
    r.e_ex = 17'(ex); r.e_ey = 17'(ey); r.e_ax = 16'(ax); r.e_ay = 16'(ay);
    r.e_lost = l; r.e_ovr = o;
    return r;
  endfunction

  vec_t tbl[19];

  initial begin
    // target {120,40} for every table frame
    tbl[0]  = mk(100, 50, 1, 1,  20, -10, 100, 50, 0, 0);
    tbl[1]  = mk(100, 50, 1, 1,  20, -10, 100, 50, 0, 0);
    tbl[2]  = mk(100, 50, 1, 1,  20, -10, 100, 50, 0, 0);
    tbl[3]  = mk(100, 50, 1, 1,  20, -10, 100, 50, 0, 0);
    tbl[4]  = mk(  0,  0, 1, 0,   0,   0, 100, 50, 0, 0);
    tbl[5]  = mk(  0,  0, 1, 0,   0,   0, 100, 50, 0, 0);
    tbl[6]  = mk(  0,  0, 1, 0,   0,   0, 100, 50, 1, 0);
    tbl[7]  = mk(200, 80, 1, 1, -80, -40, 200, 80, 0, 0);
    tbl[8]  = mk(  0,  0, 1, 0,   0,   0, 200, 80, 0, 0);
    tbl[9]  = mk(  0,  0, 1, 0,   0,   0, 200, 80, 0, 0);
    tbl[10] = mk(  0,  0, 1, 0,   0,   0, 200, 80, 1, 0);
    tbl[11] = mk(100, 50, 1, 1,  20, -10, 100, 50, 0, 0);
    tbl[12] = mk(104, 50, 1, 1,  16, -10, 104, 50, 0, 0);
    tbl[13] = mk(108, 50, 1, 1,  12, -10, 108, 50, 0, 0);
    tbl[14] = mk(112, 50, 1, 1,  14, -10, 106, 50, 0, 0);
    tbl[15] = mk(116, 50, 1, 1,  10, -10, 110, 50, 0, 0);
    tbl[16] = mk(120, 50, 0, 1,  10, -10, 114, 50, 0, 1);
    tbl[17] = mk(124, 50, 0, 1,  10, -10, 118, 50, 0, 1);
    tbl[18] = mk(128, 50, 1, 1,  -2, -10, 122, 50, 0, 1);

    reset = 1; en = 1; err_ready = 1; laser_xy = 0; target_xy = 0;
    pixel_col = 0; pixel_row = 0;
    model_reset();
    for (int p = NPIX - 4; p < NPIX; p++) step(p, 0);
    chk_reset_state();
    reset = 0;
    step(0, 0);
    step(1, 0);

    for (int i = 0; i < 19; i++) begin
      run_frame(tbl[i].xy, {16'd120, 16'd40}, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), {31'd0, err_valid}, {31'd0, tbl[i].e_v});
      if (tbl[i].e_v) begin
        chk($sformatf("tbl%0d_ex", i), {15'd0, err_x}, {15'd0, tbl[i].e_ex});
        chk($sformatf("tbl%0d_ey", i), {15'd0, err_y}, {15'd0, tbl[i].e_ey});
      end
      chk($sformatf("tbl%0d_avg", i), avg_xy, {tbl[i].e_ax, tbl[i].e_ay});
      chk($sformatf("tbl%0d_lost", i), {31'd0, lost}, {31'd0, tbl[i].e_lost});
      chk($sformatf("tbl%0d_ovr", i), {31'd0, overrun}, {31'd0, tbl[i].e_ovr});
    end

    // Reset in the middle of a frame, released at row 2: the partial
    // frame's EOF must not start a capture.
    for (int p = 2; p < 10; p++) step(p, 0);
    reset = 1;
    for (int p = 10; p < 2 * FW; p++) step(p, 0);
    chk_reset_state();
    reset = 0;
    for (int p = 2 * FW; p < NPIX; p++) step(p, 0);
    chk("partial_det_clear", {31'd0, det_clear}, 32'd0);
    chk("partial_frame_count", {16'd0, frame_count}, 32'd0);
    step(0, 0);
    chk("partial_no_capture", {31'd0, det_clear}, 32'd0);
    step(1, 0);

    // Extreme subtraction: target 0, average 65535 on both axes.
    run_frame(32'hFFFF_FFFF, 32'd0, 1);
    chk("extreme_ex", {15'd0, err_x}, 32'h0001_0001);
    chk("extreme_ey", {15'd0, err_y}, 32'h0001_0001);
    chk("extreme_avg", avg_xy, 32'hFFFF_FFFF);
    chk("after_reset_fc", {16'd0, frame_count}, 32'd1);

    // Random frames against the model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] xy;
      xy = ($urandom_range(0, 2) == 0) ? 32'd0 : ($urandom() | 32'd1);
      run_frame(xy, $urandom(), $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
